// File: rtl/codemaker_main_memory_arbiter_pkg.sv
// Shared main-memory definitions and arbitration helpers for the
// main-memory arbiter slice.

`ifndef CODEMAKER_MAIN_MEMORY_DEFINES
`define CODEMAKER_MAIN_MEMORY_DEFINES
`define MAIN_MEMORY_ADDR_BITS 8
`define MAIN_MEMORY_BASE      16'h2000
`define MAIN_MEMORY_LIMIT     16'h20FF
`endif

package codemaker_main_memory_arbiter_pkg;

   // Width of a port index; a single-port build still needs one bit.
   function automatic int ptr_bits(input int num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

   // Round-robin successor of port k among n ports.
   function automatic int rr_next(input int k, input int n);
      return (k + 1) % n;
   endfunction

endpackage

// File: rtl/codemaker_main_memory_arbiter_rr.sv
// Combinational round-robin picker: returns a one-hot winner among the
// eligible ports, searching upward from ptr with wrap-around.

module codemaker_rr_arbiter
   import codemaker_main_memory_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int PTR_BITS  = ptr_bits(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] eligible,
   input  logic [PTR_BITS-1:0]  ptr,
   output logic [NUM_PORTS-1:0] winner
);

   // First eligible port at or after ptr wins.
   always_comb begin
      int   idx;
      logic found;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int off = 0; off < NUM_PORTS; off++) begin
         idx = (int'(ptr) + off) % NUM_PORTS;
         if (!found && eligible[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/codemaker_main_memory_arbiter.sv
// Shares one single-port main-memory SRAM between NUM_PORTS core memory
// controllers. A request is granted no earlier than its second cycle, so a
// controller that is still idle never sees a grant. Read data returns the
// cycle after the grant and is then held per port until its next read.

`ifndef MAIN_MEMORY_ADDR_BITS
`define MAIN_MEMORY_ADDR_BITS 8
`endif

module codemaker_main_memory_arbiter
   import codemaker_main_memory_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_BITS = `MAIN_MEMORY_ADDR_BITS,
   parameter int DATA_BITS = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PORTS-1:0]           main_mem_req,
   output logic [NUM_PORTS-1:0]           main_mem_grant,
   input  logic [NUM_PORTS-1:0]           main_mem_we,
   input  logic [NUM_PORTS*ADDR_BITS-1:0] main_mem_addr,
   input  logic [NUM_PORTS*DATA_BITS-1:0] main_mem_in,
   output logic [NUM_PORTS*DATA_BITS-1:0] main_mem_out,
   output logic                           sram_csb0,
   output logic                           sram_web0,
   output logic [ADDR_BITS-1:0]           sram_addr0,
   output logic [DATA_BITS-1:0]           sram_din0,
   input  logic [DATA_BITS-1:0]           sram_dout0
);

   localparam int PTR_BITS = ptr_bits(NUM_PORTS);

   logic [NUM_PORTS-1:0] armed_p1;
   logic [NUM_PORTS-1:0] rd_pend_p1;
   logic [DATA_BITS-1:0] held_p1 [NUM_PORTS];
   logic [PTR_BITS-1:0]  ptr;
   logic [NUM_PORTS-1:0] eligible;
   logic [NUM_PORTS-1:0] winner;
   logic [PTR_BITS-1:0]  win_idx;
   logic                 any_grant;

   // ---- p0: arbitration and SRAM command (combinational) ----
   assign eligible       = main_mem_req & armed_p1 & {NUM_PORTS{~rst}};
   assign main_mem_grant = winner;

   codemaker_rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .PTR_BITS  (PTR_BITS)
   ) u_rr (
      .eligible (eligible),
      .ptr      (ptr),
      .winner   (winner)
   );

   // Encode the winner and steer its request onto the SRAM port.
   always_comb begin
      win_idx    = '0;
      any_grant  = |winner;
      sram_csb0  = 1'b1;
      sram_web0  = 1'b1;
      sram_addr0 = '0;
      sram_din0  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (winner[i]) win_idx = PTR_BITS'(i);
      end
      if (any_grant) begin
         sram_csb0  = 1'b0;
         sram_web0  = ~main_mem_we[win_idx];
         sram_addr0 = main_mem_addr[win_idx*ADDR_BITS +: ADDR_BITS];
         sram_din0  = main_mem_in[win_idx*DATA_BITS +: DATA_BITS];
      end
   end

   // ---- p1: arming, read-pending flags, pointer, held read data ----
   // Arming, read-pending flags and the round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         armed_p1   <= '0;
         rd_pend_p1 <= '0;
         ptr        <= '0;
      end else begin
         armed_p1   <= main_mem_req & ~winner;
         rd_pend_p1 <= winner & ~main_mem_we;
         if (any_grant) ptr <= PTR_BITS'(rr_next(int'(win_idx), NUM_PORTS));
      end
   end

   // Capture returning SRAM data into the port that issued the read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (rst) held_p1[i] <= '0;
         else if (rd_pend_p1[i]) held_p1[i] <= sram_dout0;
      end
   end

   // Forward SRAM data in its return cycle, otherwise present held data.
   always_comb begin
      main_mem_out = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!rst) begin
            main_mem_out[i*DATA_BITS +: DATA_BITS] = rd_pend_p1[i] ? sram_dout0 : held_p1[i];
         end
      end
   end

endmodule

// File: tb/tb_codemaker_main_memory_arbiter.sv
// Scoreboard bench for codemaker_main_memory_arbiter: stimulus pushes
// expected SRAM transactions and timed observations; a negedge monitor pops
// and compares them against the DUT.

module tb_codemaker_main_memory_arbiter;

   localparam int NP = 4;
   localparam int AB = 8;
   localparam int DB = 32;

   localparam int K_GRANT = 0;
   localparam int K_SRAM  = 1;
   localparam int K_DIN   = 2;
   localparam int K_OUT   = 3;
   localparam int K_PTR   = 4;

   typedef struct {
      int          at;
      int          kind;
      int          port;
      logic [31:0] val;
      string       name;
   } dexp_t;

   typedef struct {
      int          port;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] din;
      logic [31:0] rdata;
      logic        chk_data;
   } tx_t;

   logic             clk;
   logic             rst;
   logic [NP-1:0]    req_r;
   logic [NP-1:0]    keep_r;
   logic [NP-1:0]    main_mem_grant;
   logic [NP-1:0]    we_r;
   logic [NP*AB-1:0] addr_r;
   logic [NP*DB-1:0] din_r;
   logic [NP*DB-1:0] main_mem_out;
   logic             sram_csb0;
   logic             sram_web0;
   logic [AB-1:0]    sram_addr0;
   logic [DB-1:0]    sram_din0;
   logic [DB-1:0]    sram_dout0;
   logic [DB-1:0]    mem [256];

   int    cyc = 0;
   int    n_chk = 0;
   int    n_pass = 0;
   logic  done = 1'b0;
   dexp_t dq[$];
   tx_t   txq[$];

   codemaker_main_memory_arbiter #(
      .NUM_PORTS (NP),
      .ADDR_BITS (AB),
      .DATA_BITS (DB)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .main_mem_req   (req_r),
      .main_mem_grant (main_mem_grant),
      .main_mem_we    (we_r),
      .main_mem_addr  (addr_r),
      .main_mem_in    (din_r),
      .main_mem_out   (main_mem_out),
      .sram_csb0      (sram_csb0),
      .sram_web0      (sram_web0),
      .sram_addr0     (sram_addr0),
      .sram_din0      (sram_din0),
      .sram_dout0     (sram_dout0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model with preloaded contents; read data appears one cycle after select.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h05] = 32'hDEADBEEF;
      mem[8'h00] = 32'h000000A0;
      mem[8'h01] = 32'h000000A1;
      mem[8'h02] = 32'h000000A2;
      mem[8'h03] = 32'h000000A3;
      mem[8'h80] = 32'h33333333;
      sram_dout0 = 32'h0;
      forever begin
         @(posedge clk);
         if (!sram_csb0) begin
            if (!sram_web0) mem[sram_addr0] <= sram_din0;
            else sram_dout0 <= mem[sram_addr0];
         end
      end
   end

   function automatic logic [31:0] sram_code(input logic csb, input logic web, input logic [7:0] a);
      return {22'b0, csb, web, a};
   endfunction

   function automatic logic [31:0] sample(input int kind, input int port);
      case (kind)
         K_GRANT: return {28'b0, main_mem_grant};
         K_SRAM:  return {22'b0, sram_csb0, sram_web0, sram_addr0};
         K_DIN:   return sram_din0;
         K_OUT:   return main_mem_out[port*DB +: DB];
         K_PTR:   return {30'b0, dut.ptr};
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", nm, cyc, act, exp);
   endtask

   // Monitor: compares scheduled observations and every granted transaction.
   initial begin
      logic        pend_v;
      int          pend_port;
      logic [31:0] pend_data;
      logic        fin;
      tx_t         t;
      logic        web_exp;
      pend_v = 1'b0;
      pend_port = 0;
      pend_data = '0;
      fin = 1'b0;
      forever begin
         @(negedge clk);
         if (pend_v) begin
            chk($sformatf("tx_rdata_port%0d", pend_port), main_mem_out[pend_port*DB +: DB], pend_data);
            pend_v = 1'b0;
         end
         for (int i = dq.size() - 1; i >= 0; i--) begin
            if (dq[i].at == cyc) begin
               chk(dq[i].name, sample(dq[i].kind, dq[i].port), dq[i].val);
               dq.delete(i);
            end
         end
         if (main_mem_grant != '0) begin
            if (txq.size() == 0) begin
               chk("tx_unexpected_grant", {28'b0, main_mem_grant}, 32'h0);
            end else begin
               t = txq.pop_front();
               web_exp = ~t.we;
               chk("tx_grant", {28'b0, main_mem_grant}, 32'(1) << t.port);
               chk("tx_csb", {31'b0, sram_csb0}, 32'h0);
               chk("tx_web", {31'b0, sram_web0}, {31'b0, web_exp});
               chk("tx_addr", {24'b0, sram_addr0}, {24'b0, t.addr});
               chk("tx_din", sram_din0, t.din);
               if (!t.we && t.chk_data) begin
                  pend_v = 1'b1;
                  pend_port = t.port;
                  pend_data = t.rdata;
               end
            end
         end
         if (done && !fin) begin
            chk("expectations_left", dq.size(), 32'h0);
            chk("transactions_left", txq.size(), 32'h0);
            fin = 1'b1;
         end
      end
   end

   task automatic expect_at(input int at, input int kind, input int port, input logic [31:0] val, input string nm);
      dexp_t e;
      e.at = at;
      e.kind = kind;
      e.port = port;
      e.val = val;
      e.name = nm;
      dq.push_back(e);
   endtask

   task automatic push_tx(input int p, input logic we, input logic [7:0] a, input logic [31:0] d, input logic [31:0] rd, input logic cd);
      tx_t t;
      t.port = p;
      t.we = we;
      t.addr = a;
      t.din = d;
      t.rdata = rd;
      t.chk_data = cd;
      txq.push_back(t);
   endtask

   task automatic set_port(input int p, input logic we, input logic [7:0] a, input logic [31:0] d);
      we_r[p] = we;
      addr_r[p*AB +: AB] = a;
      din_r[p*DB +: DB] = d;
   endtask

   // One clock: a port granted this cycle drops req unless it keeps requesting.
   task automatic tick();
      logic [NP-1:0] g;
      @(negedge clk);
      g = main_mem_grant;
      @(posedge clk);
      #1;
      req_r = req_r & (~g | keep_r);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Directed stimulus.
   initial begin
      int C;
      rst = 1'b1;
      req_r = '0;
      keep_r = '0;
      we_r = '0;
      addr_r = '0;
      din_r = '0;
      @(posedge clk);
      #1;

      // Reset state
      C = cyc;
      expect_at(C, K_GRANT, 0, 32'h0, "rst_grant");
      expect_at(C, K_SRAM, 0, sram_code(1'b1, 1'b1, 8'h00), "rst_sram");
      for (int p = 0; p < NP; p++) expect_at(C + 1, K_OUT, p, 32'h0, "rst_out");
      ticks(2);
      rst = 1'b0;
      C = cyc;
      expect_at(C, K_PTR, 0, 32'h0, "rst_ptr");
      for (int p = 0; p < NP; p++) expect_at(C, K_OUT, p, 32'h0, "post_rst_out");

      // Single read by port 0
      set_port(0, 1'b0, 8'h05, 32'h0);
      req_r[0] = 1'b1;
      push_tx(0, 1'b0, 8'h05, 32'h0, 32'hDEADBEEF, 1'b1);
      expect_at(C, K_GRANT, 0, 32'h0, "t1_first_cycle_no_grant");
      expect_at(C + 1, K_GRANT, 0, 32'h1, "t1_grant");
      expect_at(C + 1, K_SRAM, 0, sram_code(1'b0, 1'b1, 8'h05), "t1_sram");
      expect_at(C + 2, K_OUT, 0, 32'hDEADBEEF, "t1_out");
      expect_at(C + 9, K_OUT, 0, 32'hDEADBEEF, "t1_out_held");
      ticks(10);

      // Port 1 writes, then keeps requesting to read the same word
      C = cyc;
      set_port(1, 1'b1, 8'h10, 32'h12345678);
      req_r[1] = 1'b1;
      keep_r[1] = 1'b1;
      push_tx(1, 1'b1, 8'h10, 32'h12345678, 32'h0, 1'b0);
      push_tx(1, 1'b0, 8'h10, 32'h0, 32'h12345678, 1'b1);
      expect_at(C + 1, K_GRANT, 0, 32'h2, "t2_write_grant");
      expect_at(C + 1, K_SRAM, 0, sram_code(1'b0, 1'b0, 8'h10), "t2_write_sram");
      expect_at(C + 1, K_DIN, 0, 32'h12345678, "t2_write_din");
      expect_at(C + 2, K_GRANT, 0, 32'h0, "t2_rearm_gap");
      expect_at(C + 2, K_OUT, 1, 32'h0, "t2_out_after_write");
      expect_at(C + 3, K_GRANT, 0, 32'h2, "t2_read_grant");
      expect_at(C + 3, K_SRAM, 0, sram_code(1'b0, 1'b1, 8'h10), "t2_read_sram");
      expect_at(C + 4, K_OUT, 1, 32'h12345678, "t2_read_out");
      expect_at(C + 8, K_OUT, 1, 32'h12345678, "t2_read_held");
      ticks(2);
      set_port(1, 1'b0, 8'h10, 32'h0);
      keep_r[1] = 1'b0;
      ticks(8);

      // Port 3 read: pointer wraps to 0
      C = cyc;
      set_port(3, 1'b0, 8'h80, 32'h0);
      req_r[3] = 1'b1;
      push_tx(3, 1'b0, 8'h80, 32'h0, 32'h33333333, 1'b1);
      expect_at(C + 1, K_GRANT, 0, 32'h8, "t3pre_grant");
      expect_at(C + 2, K_PTR, 0, 32'h0, "t3pre_ptr_wrap");
      ticks(4);

      // Contention: all four ports read back-to-back
      C = cyc;
      for (int p = 0; p < NP; p++) begin
         set_port(p, 1'b0, 8'(p), 32'h0);
         push_tx(p, 1'b0, 8'(p), 32'h0, 32'hA0 + 32'(p), 1'b1);
         expect_at(C + 1 + p, K_GRANT, 0, 32'(1) << p, "t3_grant_order");
         expect_at(C + 2 + p, K_OUT, p, 32'hA0 + 32'(p), "t3_out");
         expect_at(C + 7, K_OUT, p, 32'hA0 + 32'(p), "t3_out_held");
      end
      req_r = 4'hF;
      expect_at(C, K_GRANT, 0, 32'h0, "t3_first_cycle_no_grant");
      ticks(8);

      // Fairness: ports 0 and 2 request continuously
      C = cyc;
      set_port(0, 1'b0, 8'h00, 32'h0);
      set_port(2, 1'b0, 8'h02, 32'h0);
      req_r = 4'b0101;
      keep_r = 4'b0101;
      for (int n = 0; n < 6; n++) begin
         if (n % 2 == 0) begin
            expect_at(C + 1 + n, K_GRANT, 0, 32'h1, "t4_alternate");
            push_tx(0, 1'b0, 8'h00, 32'h0, 32'hA0, 1'b1);
         end else begin
            expect_at(C + 1 + n, K_GRANT, 0, 32'h4, "t4_alternate");
            push_tx(2, 1'b0, 8'h02, 32'h0, 32'hA2, 1'b1);
         end
      end
      ticks(7);
      req_r = '0;
      keep_r = '0;
      expect_at(cyc, K_GRANT, 0, 32'h0, "t4_stop");
      ticks(3);

      // Idle: no requests for 20 cycles
      C = cyc;
      expect_at(C, K_PTR, 0, 32'h3, "t6_ptr_start");
      for (int n = 0; n < 20; n++) begin
         expect_at(C + n, K_GRANT, 0, 32'h0, "t6_idle_grant");
         expect_at(C + n, K_SRAM, 0, sram_code(1'b1, 1'b1, 8'h00), "t6_idle_sram");
      end
      expect_at(C + 10, K_DIN, 0, 32'h0, "t6_idle_din");
      expect_at(C + 19, K_PTR, 0, 32'h3, "t6_ptr_end");
      ticks(20);

      // Reset in the cycle after a port 3 read grant
      C = cyc;
      set_port(3, 1'b0, 8'h03, 32'h0);
      req_r[3] = 1'b1;
      push_tx(3, 1'b0, 8'h03, 32'h0, 32'hA3, 1'b0);
      expect_at(C + 1, K_GRANT, 0, 32'h8, "t5_grant");
      expect_at(C + 2, K_GRANT, 0, 32'h0, "t5_rst_grant");
      expect_at(C + 2, K_SRAM, 0, sram_code(1'b1, 1'b1, 8'h00), "t5_rst_sram");
      for (int p = 0; p < NP; p++) begin
         expect_at(C + 2, K_OUT, p, 32'h0, "t5_rst_out");
         expect_at(C + 3, K_OUT, p, 32'h0, "t5_rst_out_hold");
      end
      ticks(2);
      rst = 1'b1;
      ticks(2);
      rst = 1'b0;
      req_r[3] = 1'b1;
      push_tx(3, 1'b0, 8'h03, 32'h0, 32'hA3, 1'b1);
      expect_at(C + 4, K_GRANT, 0, 32'h0, "t5_post_rst_wait");
      expect_at(C + 4, K_OUT, 3, 32'h0, "t5_pending_dropped");
      expect_at(C + 4, K_PTR, 0, 32'h0, "t5_ptr_reset");
      expect_at(C + 5, K_GRANT, 0, 32'h8, "t5_regrant");
      expect_at(C + 6, K_OUT, 3, 32'hA3, "t5_out");
      ticks(8);

      done = 1'b1;
      ticks(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
